// File: rtl/pid_pkg.sv
// pid_pkg: shared constants and types for the PID effort calculator.
package pid_pkg;
  localparam int PID_FRAC  = 8;
  localparam int PID_ACC_W = 34;
  localparam int NPROD     = 9;
  localparam int S16_MAX   = 32767;
  localparam int S16_MIN   = -32768;
  localparam logic [3:0] IDX_ROLL = 4'd3;
  localparam logic [3:0] IDX_YAW  = 4'd6;
  localparam logic [3:0] IDX_LAST = 4'd8;
  typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;
endpackage

// File: rtl/pid_if.sv
// pid_if: error/gain inputs and effort outputs between the control loop and pid_calc.
interface pid_if;
  logic calc_en;
  logic signed [15:0] pitch_error, roll_error, yaw_error;
  logic signed [15:0] i_pitch_error, i_roll_error, i_yaw_error;
  logic signed [15:0] d_pitch_error, d_roll_error, d_yaw_error;
  logic signed [15:0] kp_pitch, ki_pitch, kd_pitch;
  logic signed [15:0] kp_roll, ki_roll, kd_roll;
  logic signed [15:0] kp_yaw, ki_yaw, kd_yaw;
  logic signed [15:0] pitch_out, roll_out, yaw_out;
  logic busy, done;
  modport master (
    output calc_en, pitch_error, roll_error, yaw_error,
           i_pitch_error, i_roll_error, i_yaw_error,
           d_pitch_error, d_roll_error, d_yaw_error,
           kp_pitch, ki_pitch, kd_pitch, kp_roll, ki_roll, kd_roll,
           kp_yaw, ki_yaw, kd_yaw,
    input  pitch_out, roll_out, yaw_out, busy, done
  );
  modport slave (
    input  calc_en, pitch_error, roll_error, yaw_error,
           i_pitch_error, i_roll_error, i_yaw_error,
           d_pitch_error, d_roll_error, d_yaw_error,
           kp_pitch, ki_pitch, kd_pitch, kp_roll, ki_roll, kd_roll,
           kp_yaw, ki_yaw, kd_yaw,
    output pitch_out, roll_out, yaw_out, busy, done
  );
endinterface

// File: rtl/pid_calc_sat.sv
// pid_sat: floor-shift an accumulator by FRAC and clamp it to signed 16 bits.
module pid_sat
  import pid_pkg::*;
#(
  parameter int FRAC  = PID_FRAC,
  parameter int ACC_W = PID_ACC_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [15:0]      sat_o
);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(S16_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(S16_MIN);
  logic signed [ACC_W-1:0] shr;
  always_comb begin
    shr   = acc_i >>> FRAC;
    sat_o = shr > HI ? 16'sh7fff : shr < LO ? 16'sh8000 : shr[15:0];
  end
endmodule

// File: rtl/pid_calc.sv
// pid_calc: nine-product PID MAC on one shared multiplier, saturated per-axis efforts.
module pid_calc
  import pid_pkg::*;
#(
  parameter int FRAC  = PID_FRAC,
  parameter int ACC_W = PID_ACC_W
) (
  input logic clk,
  input logic rst,
  pid_if.slave bus
);
  state_t                  state_q;
  logic [3:0]              idx_q;
  logic signed [15:0]      err_q  [NPROD];
  logic signed [15:0]      gain_q [NPROD];
  logic signed [ACC_W-1:0] acc_q  [3];
  logic signed [15:0]      out_q  [3];
  logic signed [15:0]      sat_d  [3];
  logic                    busy_q, done_q;
  logic signed [31:0]      prod_d;
  logic signed [ACC_W-1:0] prod_x;
  logic [1:0]              axis_d;
  always_comb begin
    prod_d = err_q[idx_q] * gain_q[idx_q];
    prod_x = ACC_W'(prod_d);
    axis_d = idx_q < IDX_ROLL ? 2'd0 : idx_q < IDX_YAW ? 2'd1 : 2'd2;
  end
  for (genvar g = 0; g < 3; g++) begin : g_sat
    pid_sat #(.FRAC(FRAC), .ACC_W(ACC_W)) u_sat (.acc_i(acc_q[g]), .sat_o(sat_d[g]));
  end
  // busy mirrors MAC one edge late so it covers exactly the nine product edges
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= '0;
        out_q[i] <= '0;
      end
      for (int i = 0; i < NPROD; i++) begin
        err_q[i]  <= '0;
        gain_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      busy_q <= state_q == MAC;
      case (state_q)
        IDLE: if (bus.calc_en) begin
          err_q  <= '{bus.pitch_error, bus.i_pitch_error, bus.d_pitch_error,
                      bus.roll_error,  bus.i_roll_error,  bus.d_roll_error,
                      bus.yaw_error,   bus.i_yaw_error,   bus.d_yaw_error};
          gain_q <= '{bus.kp_pitch, bus.ki_pitch, bus.kd_pitch,
                      bus.kp_roll,  bus.ki_roll,  bus.kd_roll,
                      bus.kp_yaw,   bus.ki_yaw,   bus.kd_yaw};
          for (int i = 0; i < 3; i++) acc_q[i] <= '0;
          idx_q   <= '0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q[axis_d] <= acc_q[axis_d] + prod_x;
          idx_q         <= idx_q + 4'd1;
          state_q       <= idx_q == IDX_LAST ? SAT : MAC;
        end
        SAT: begin
          for (int i = 0; i < 3; i++) out_q[i] <= sat_d[i];
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.pitch_out = out_q[0];
  assign bus.roll_out  = out_q[1];
  assign bus.yaw_out   = out_q[2];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_pid_calc.sv
// tb_pid_calc: directed checks of pid_calc arithmetic, latency, handshake and reset.
module tb_pid_calc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  pid_if bus ();
  pid_calc dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.calc_en = 0;
    bus.pitch_error = 0; bus.roll_error = 0; bus.yaw_error = 0;
    bus.i_pitch_error = 0; bus.i_roll_error = 0; bus.i_yaw_error = 0;
    bus.d_pitch_error = 0; bus.d_roll_error = 0; bus.d_yaw_error = 0;
    bus.kp_pitch = 0; bus.ki_pitch = 0; bus.kd_pitch = 0;
    bus.kp_roll = 0; bus.ki_roll = 0; bus.kd_roll = 0;
    bus.kp_yaw = 0; bus.ki_yaw = 0; bus.kd_yaw = 0;
  endtask

  // pulse calc_en and return the number of edges until done (0 if it never came)
  task automatic run_calc(output int lat);
    lat = 0;
    bus.calc_en = 1;
    tick;
    bus.calc_en = 0;
    for (int n = 1; n <= 20; n++) begin
      tick;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    clear_inputs;
    rst = 1;
    tick; tick;
    rst = 0;
    n_chk++;
    if ({bus.pitch_out, bus.roll_out, bus.yaw_out} !== 48'd0) $display("FAIL reset_outs got %h want 0", {bus.pitch_out, bus.roll_out, bus.yaw_out});
    else n_pass++;
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_busy_done got %b want 00", {bus.busy, bus.done});
    else n_pass++;
  endtask

  task automatic test_unity_latency;
    clear_inputs;
    bus.kp_pitch = 256; bus.pitch_error = 100;
    bus.calc_en = 1;
    tick;
    bus.calc_en = 0;
    for (int n = 1; n <= 9; n++) begin
      tick;
      n_chk++;
      if ({bus.busy, bus.done} !== 2'b10) $display("FAIL busy_window edge k+%0d got busy,done=%b want 10", n, {bus.busy, bus.done});
      else n_pass++;
    end
    tick;
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b01) $display("FAIL done_edge10 got busy,done=%b want 01", {bus.busy, bus.done});
    else n_pass++;
    n_chk++;
    if (bus.pitch_out !== 16'sd100 || bus.roll_out !== 16'sd0 || bus.yaw_out !== 16'sd0)
      $display("FAIL unity got %0d,%0d,%0d want 100,0,0", bus.pitch_out, bus.roll_out, bus.yaw_out);
    else n_pass++;
    tick;
    n_chk++;
    if (bus.done !== 1'b0) $display("FAIL done_one_cycle got %b want 0", bus.done);
    else n_pass++;
    n_chk++;
    if (bus.pitch_out !== 16'sd100) $display("FAIL hold_out got %0d want 100", bus.pitch_out);
    else n_pass++;
  endtask

  task automatic test_mixed;
    int lat;
    clear_inputs;
    bus.kp_pitch = 256; bus.ki_pitch = 64; bus.kd_pitch = 512;
    bus.pitch_error = 100; bus.i_pitch_error = 400; bus.d_pitch_error = -50;
    bus.kp_roll = 128; bus.roll_error = 3;
    bus.kp_yaw = 1; bus.yaw_error = -1;
    run_calc(lat);
    n_chk++;
    if (lat != 10) $display("FAIL mixed_latency got %0d want 10", lat);
    else n_pass++;
    n_chk++;
    if (bus.pitch_out !== 16'sd100) $display("FAIL mixed_pitch got %0d want 100", bus.pitch_out);
    else n_pass++;
    n_chk++;
    if (bus.roll_out !== 16'sd1) $display("FAIL mixed_roll got %0d want 1", bus.roll_out);
    else n_pass++;
    n_chk++;
    if (bus.yaw_out !== -16'sd1) $display("FAIL mixed_yaw_floor got %0d want -1", bus.yaw_out);
    else n_pass++;
  endtask

  task automatic test_saturation;
    int lat;
    clear_inputs;
    bus.kp_pitch = 32767; bus.ki_pitch = 32767; bus.kd_pitch = 32767;
    bus.pitch_error = 32767; bus.i_pitch_error = 32767; bus.d_pitch_error = 32767;
    bus.kp_roll = 32767; bus.roll_error = -32768;
    bus.kp_yaw = -32768; bus.yaw_error = -32768;
    run_calc(lat);
    n_chk++;
    if (lat != 10) $display("FAIL sat_latency got %0d want 10", lat);
    else n_pass++;
    n_chk++;
    if (bus.pitch_out !== 16'sd32767) $display("FAIL sat_pitch_pos got %0d want 32767", bus.pitch_out);
    else n_pass++;
    n_chk++;
    if (bus.roll_out !== -16'sd32768) $display("FAIL sat_roll_neg got %0d want -32768", bus.roll_out);
    else n_pass++;
    n_chk++;
    if (bus.yaw_out !== 16'sd32767) $display("FAIL sat_yaw_minmin got %0d want 32767", bus.yaw_out);
    else n_pass++;
  endtask

  // re-pulses at k+3/k+5 ignored; operands changed at k+4 do not leak in
  task automatic test_ignore_busy;
    int cnt = 0;
    int at = 0;
    clear_inputs;
    bus.kp_pitch = 256; bus.pitch_error = 50;
    bus.kp_roll = 512; bus.roll_error = -7;
    bus.calc_en = 1;
    tick;
    for (int n = 1; n <= 30; n++) begin
      bus.calc_en = (n == 3 || n == 5);
      if (n == 4) begin
        bus.pitch_error = 1000; bus.kp_pitch = 512; bus.roll_error = 9;
      end
      tick;
      if (bus.done === 1'b1) begin
        cnt++;
        if (at == 0) at = n;
      end
    end
    n_chk++;
    if (cnt != 1) $display("FAIL ignore_busy_done_count got %0d want 1", cnt);
    else n_pass++;
    n_chk++;
    if (at != 10) $display("FAIL ignore_busy_done_edge got %0d want 10", at);
    else n_pass++;
    n_chk++;
    if (bus.pitch_out !== 16'sd50 || bus.roll_out !== -16'sd14)
      $display("FAIL latched_operands got %0d,%0d want 50,-14", bus.pitch_out, bus.roll_out);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int d1 = 0;
    int d2 = 0;
    logic signed [15:0] p1 = 0;
    logic signed [15:0] p2 = 0;
    clear_inputs;
    bus.kp_pitch = 256; bus.pitch_error = 10;
    bus.calc_en = 1;
    tick;
    for (int n = 1; n <= 30; n++) begin
      bus.calc_en = (n <= 11);
      if (n == 2) bus.pitch_error = 20;
      tick;
      if (bus.done === 1'b1) begin
        if (d1 == 0) begin d1 = n; p1 = bus.pitch_out; end
        else if (d2 == 0) begin d2 = n; p2 = bus.pitch_out; end
      end
    end
    n_chk++;
    if (d1 != 10 || d2 != 21) $display("FAIL b2b_done_edges got %0d,%0d want 10,21", d1, d2);
    else n_pass++;
    n_chk++;
    if (p1 !== 16'sd10 || p2 !== 16'sd20) $display("FAIL b2b_results got %0d,%0d want 10,20", p1, p2);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat;
    int cnt = 0;
    clear_inputs;
    bus.kp_pitch = 256; bus.pitch_error = 77;
    run_calc(lat);
    n_chk++;
    if (bus.pitch_out !== 16'sd77) $display("FAIL pre_reset_pitch got %0d want 77", bus.pitch_out);
    else n_pass++;
    bus.pitch_error = 500;
    bus.calc_en = 1;
    tick;
    bus.calc_en = 0;
    for (int n = 1; n <= 4; n++) tick;
    rst = 1;
    tick;
    rst = 0;
    n_chk++;
    if (bus.pitch_out !== 16'sd0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL mid_reset got pitch=%0d busy=%b done=%b want 0,0,0", bus.pitch_out, bus.busy, bus.done);
    else n_pass++;
    for (int n = 0; n < 15; n++) begin
      tick;
      if (bus.done === 1'b1) cnt++;
    end
    n_chk++;
    if (cnt != 0 || bus.pitch_out !== 16'sd0) $display("FAIL aborted_no_done got dones=%0d pitch=%0d want 0,0", cnt, bus.pitch_out);
    else n_pass++;
    clear_inputs;
    bus.kp_pitch = 256; bus.pitch_error = 33;
    bus.kp_roll = 256; bus.roll_error = -5;
    run_calc(lat);
    n_chk++;
    if (lat != 10 || bus.pitch_out !== 16'sd33 || bus.roll_out !== -16'sd5)
      $display("FAIL post_reset_calc got lat=%0d %0d,%0d want 10 33,-5", lat, bus.pitch_out, bus.roll_out);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_unity_latency;
    test_mixed;
    test_saturation;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
